// File: rtl/eth_tx_arb_pkg.sv
// Shared types and defaults for the two-source Ethernet TX arbiter.
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      GAP    = 2'd3
   } arb_state_t;

   localparam int unsigned IFG_CYCLES_DEFAULT     = 12;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

   // Counter widths cover the full legal range of each parameter.
   localparam int unsigned IFG_W = 8;
   localparam int unsigned WD_W  = 16;

endpackage

// File: rtl/eth_arb_timer.sv
// Loadable down-counter with zero flag; used for the inter-frame gap and the stall watchdog.
module eth_arb_timer
   import eth_tx_arb_pkg::*;
#(
   parameter int unsigned WIDTH = IFG_W
) (
   input  logic             i_clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_count,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   // Load wins over decrement; the count holds at zero.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter merging two byte streams onto one Ethernet TX stream,
// with an enforced inter-frame gap. Optional stall watchdog: ETH_TX_ARB_WATCHDOG_EN.
module eth_tx_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int unsigned IFG_CYCLES     = IFG_CYCLES_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic       i_clk,
   input  logic       rst,
   input  logic       i_s0_valid,
   input  logic [7:0] i_s0_data,
   input  logic       i_s0_last,
   output logic       o_s0_ready,
   input  logic       i_s1_valid,
   input  logic [7:0] i_s1_data,
   input  logic       i_s1_last,
   output logic       o_s1_ready,
   output logic       o_tx_valid,
   output logic [7:0] o_tx_data,
   output logic       o_tx_last,
   input  logic       i_tx_ready,
   output logic [1:0] o_grant,
   output logic       o_tx_abort
);

   localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES);

   if (IFG_CYCLES > 255) begin : g_bad_ifg
      $error("IFG_CYCLES must be 0..255");
   end
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be 1..65535");
   end

   arb_state_t       r_state;
   logic             r_last_grant;  // 0: s0 was granted last, 1: s1
   logic             r_abort;
   logic             w_gnt0, w_gnt1, w_in_grant;
   logic             w_src_valid, w_src_last, w_beat, w_frame_end;
   logic             w_req0, w_req1;
   logic [1:0]       w_disc;
   logic             w_wd_abort;
   logic [IFG_W-1:0] w_ifg_cnt;
   logic             w_ifg_zero, w_gap_done;

   assign w_gnt0      = (r_state == GRANT0);
   assign w_gnt1      = (r_state == GRANT1);
   assign w_in_grant  = w_gnt0 | w_gnt1;
   assign w_src_valid = w_gnt0 ? i_s0_valid : (w_gnt1 & i_s1_valid);
   assign w_src_last  = w_gnt0 ? i_s0_last : i_s1_last;
   assign w_beat      = w_src_valid & i_tx_ready;
   assign w_frame_end = w_beat & w_src_last;
   assign w_req0      = i_s0_valid & ~w_disc[0];
   assign w_req1      = i_s1_valid & ~w_disc[1];

   assign o_tx_valid = w_src_valid;
   assign o_tx_data  = w_gnt0 ? i_s0_data : (w_gnt1 ? i_s1_data : 8'h00);
   assign o_tx_last  = w_gnt0 ? i_s0_last : (w_gnt1 & i_s1_last);
   assign o_s0_ready = (w_gnt0 & i_tx_ready) | w_disc[0];
   assign o_s1_ready = (w_gnt1 & i_tx_ready) | w_disc[1];
   assign o_grant    = {w_gnt1, w_gnt0};
   assign o_tx_abort = r_abort;

   // Gap counter: loaded with IFG_CYCLES when a frame ends, counts down through GAP.
   eth_arb_timer #(
      .WIDTH (IFG_W)
   ) u_ifg_timer (
      .i_clk      (i_clk),
      .rst        (rst),
      .i_load     (w_frame_end | w_wd_abort),
      .i_load_val (IFG_LOAD),
      .i_dec      (r_state == GAP),
      .o_count    (w_ifg_cnt),
      .o_zero     (w_ifg_zero)
   );

   assign w_gap_done = (w_ifg_cnt == IFG_W'(1)) | w_ifg_zero;

`ifdef ETH_TX_ARB_WATCHDOG_EN
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES);

   logic            w_stall;
   logic [WD_W-1:0] w_wd_cnt;
   logic            w_wd_zero;
   logic [1:0]      r_disc;
   logic [1:0]      w_disc_clr;

   // Only a granted source holding valid low counts; backpressure reloads the count.
   assign w_stall = w_in_grant & ~w_src_valid;

   eth_arb_timer #(
      .WIDTH (WD_W)
   ) u_wd_timer (
      .i_clk      (i_clk),
      .rst        (rst),
      .i_load     (~w_stall),
      .i_load_val (WD_LOAD),
      .i_dec      (w_stall),
      .o_count    (w_wd_cnt),
      .o_zero     (w_wd_zero)
   );

   assign w_wd_abort = w_stall & ((w_wd_cnt == WD_W'(1)) | w_wd_zero);
   assign w_disc_clr = {i_s1_valid & i_s1_last, i_s0_valid & i_s0_last} & r_disc;

   // Discard flag: set for the aborted source, dropped once its last byte is swallowed.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         r_disc <= 2'b00;
      end else begin
         r_disc <= (r_disc & ~w_disc_clr) | ({w_gnt1, w_gnt0} & {2{w_wd_abort}});
      end
   end

   assign w_disc = r_disc;
`else
   assign w_wd_abort = 1'b0;
   assign w_disc     = 2'b00;
`endif

   // Arbitration FSM: grant in IDLE only, hold for a whole frame, then enforce the gap.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_abort      <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req0 && (!w_req1 || r_last_grant)) begin
                  r_state      <= GRANT0;
                  r_last_grant <= 1'b0;
               end else if (w_req1) begin
                  r_state      <= GRANT1;
                  r_last_grant <= 1'b1;
               end
            end
            GRANT0, GRANT1: begin
               if (w_frame_end || w_wd_abort) begin
                  r_abort <= w_wd_abort;
                  r_state <= (IFG_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (w_gap_done) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // w_in_grant feeds only the watchdog; keep it referenced in the default build too.
   logic w_unused;
   assign w_unused = w_in_grant;

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, 12, minimum idle cycles on o_tx_* between frames (0..255).
REQ-002 Parameter TIMEOUT_CYCLES, 1024, mid-frame stall limit for the watchdog (1..65535).
REQ-003 Port i_clk  in  1  125 MHz Ethernet clock; the only clock.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports i_s0_valid/i_s1_valid  in  1  source byte valid.
REQ-006 Ports i_s0_data/i_s1_data  in  8  source byte.
REQ-007 Ports i_s0_last/i_s1_last  in  1  final byte of source frame.
REQ-008 Ports o_s0_ready/o_s1_ready  out  1  source byte accepted.
REQ-009 Ports o_tx_valid  out  1, o_tx_data  out  8, o_tx_last  out  1  arbitrated stream to the Ethernet connection.
REQ-010 Port i_tx_ready  in  1  downstream flow control.
REQ-011 Port o_grant  out  2  one-hot current owner, 2'b00 when none.
REQ-012 Port o_tx_abort  out  1  one-cycle pulse on watchdog abort.

Function
REQ-013 FSM states: IDLE, GRANT0, GRANT1, GAP.
REQ-014 Beat transfers on a cycle where the granted source's valid and i_tx_ready are both 1.
REQ-015 In GRANTn: o_tx_valid/data/last combinationally equal source n's signals; o_sn_ready = i_tx_ready; the other source's ready = 0 unless its discard flag is set.
REQ-016 In IDLE and GAP: o_tx_valid = 0, both readies 0 except discard flags; no beat passes.
REQ-017 IDLE arbitration: single requester is granted next cycle; both requesting -> grant the source not granted last (last_grant reset value = 1, so s0 wins first).
REQ-018 Grant is frame-atomic; transfer with last=1 ends the grant and the frame.
REQ-019 After last: IFG_CYCLES>0 -> GAP with counter = IFG_CYCLES, decrement each cycle, IDLE when counter reaches 1; IFG_CYCLES=0 -> IDLE directly.
REQ-020 Requests arriving during GAP wait; arbitration occurs only in IDLE.
REQ-021 Minimum frame-to-frame turnaround: 1 + IFG_CYCLES cycles of o_tx_valid=0.
REQ-022 o_grant = 2'b01 in GRANT0, 2'b10 in GRANT1, else 2'b00.

Reset
REQ-023 On rst: state IDLE, last_grant = 1, counters 0, discard flags 0, o_tx_abort 0, o_grant 0, o_tx_valid 0, readies 0.
REQ-024 rst mid-frame truncates silently; no last emitted, no abort pulse.

Configuration
REQ-025 Macro ETH_TX_ARB_WATCHDOG_EN defined: in GRANTn, count consecutive cycles with source valid=0; at TIMEOUT_CYCLES pulse o_tx_abort, set discard flag n, enter GAP (or IDLE if IFG_CYCLES=0).
REQ-026 Counter clears on any cycle with granted valid=1; downstream backpressure (i_tx_ready=0) does not count.
REQ-027 Discard flag n: o_sn_ready=1, bytes dropped, source n excluded from arbitration; cleared on the cycle its last=1 byte is consumed.
REQ-028 Macro undefined: no watchdog logic, o_tx_abort tied 0, discard flags absent, a stalled source holds the grant indefinitely.

Structure
REQ-029 Package eth_tx_arb_pkg holds the state enum, IFG default, TIMEOUT default.
REQ-030 Sub-module eth_arb_timer: loadable down-counter with zero flag, instanced for IFG and watchdog.

Verification
REQ-031 s0 sends 64-byte frame alone, ready=1 -> 64 beats out, o_grant=01, then 13 idle cycles before next frame.
REQ-032 s0 and s1 request together from reset -> s0 frame, 12-cycle gap, s1 frame, then s0 again if both still pending.
REQ-033 i_tx_ready toggles 1/0 every cycle on 10-byte frame -> 10 beats, data order intact, no duplication, 19 cycles duration.
REQ-034 s1 requests during GAP after s0 frame -> s1 granted only after gap, IDLE+1 cycle.
REQ-035 WATCHDOG_EN, TIMEOUT_CYCLES=16: s0 stalls after byte 5 for 16 cycles -> abort pulse, s1 served next, s0 remaining bytes dropped to its last.
REQ-036 rst asserted mid-frame -> all outputs 0 same cycle, s0 wins first arbitration after release.
